// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier: retires D multiplier bits per clock and
// delivers the full 2W-bit product after W/D iterations with a start/ready handshake.
module seq_multiplier #(
  parameter int W = 32,
  parameter int D = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           Start_i,
  input  logic           Sgn_i,
  input  logic [W-1:0]   Data_A_i,
  input  logic [W-1:0]   Data_B_i,
  output logic           Busy_o,
  output logic           Ready_o,
  output logic [2*W-1:0] Data_S_o
);

  localparam int N  = W / D;
  localparam int P  = 2 * W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic          neg;
  logic [P-1:0]  acc;
  logic [CW-1:0] count;

  logic [W+D-1:0] pp;
  logic [P-1:0]   addend;
  logic [P-1:0]   acc_next;
  logic [P-1:0]   result;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic           start_neg;

  // Operands are reduced to magnitudes; -2^(W-1) maps to 2^(W-1), which still fits.
  always_comb begin
    abs_a     = (Sgn_i && Data_A_i[W-1]) ? (~Data_A_i + W'(1)) : Data_A_i;
    abs_b     = (Sgn_i && Data_B_i[W-1]) ? (~Data_B_i + W'(1)) : Data_B_i;
    start_neg = Sgn_i & (Data_A_i[W-1] ^ Data_B_i[W-1]);
  end

  always_comb begin
    pp = '0;
    for (int j = 0; j < D; j++) begin
      if (mag_b[j]) begin
        pp = pp + ((W+D)'(mag_a) << j);
      end
    end
    addend   = P'(pp) << (D * int'(count));
    acc_next = acc + addend;
    result   = neg ? (~acc_next + P'(1)) : acc_next;
  end

  // DONE accepts a new start on its way back to IDLE so that held or
  // immediately repeated requests achieve one product every N+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mag_a    <= '0;
      mag_b    <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      count    <= '0;
      Busy_o   <= 1'b0;
      Ready_o  <= 1'b0;
      Data_S_o <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Ready_o <= 1'b0;
          Busy_o  <= 1'b0;
          state   <= IDLE;
          if (Start_i) begin
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            neg    <= start_neg;
            acc    <= '0;
            count  <= '0;
            Busy_o <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          mag_b <= mag_b >> D;
          count <= count + CW'(1);
          if (count == LAST) begin
            Data_S_o <= result;
            Ready_o  <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          state   <= IDLE;
          Busy_o  <= 1'b0;
          Ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases at W=8/D=2 and a
// randomized sweep over several (W,D) configurations against an arithmetic model.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  start = '0;
  logic [4:0]  busy;
  logic [4:0]  ready;
  logic [15:0] s0;
  logic [63:0] s1, s2, s3;
  logic [31:0] s4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.W(8),  .D(2))  u0 (.clk(clk), .rst_n(rst_n), .Start_i(start[0]), .Sgn_i(sgn),
    .Data_A_i(a[7:0]),  .Data_B_i(b[7:0]),  .Busy_o(busy[0]), .Ready_o(ready[0]), .Data_S_o(s0));
  seq_multiplier #(.W(32), .D(2))  u1 (.clk(clk), .rst_n(rst_n), .Start_i(start[1]), .Sgn_i(sgn),
    .Data_A_i(a),       .Data_B_i(b),       .Busy_o(busy[1]), .Ready_o(ready[1]), .Data_S_o(s1));
  seq_multiplier #(.W(32), .D(1))  u2 (.clk(clk), .rst_n(rst_n), .Start_i(start[2]), .Sgn_i(sgn),
    .Data_A_i(a),       .Data_B_i(b),       .Busy_o(busy[2]), .Ready_o(ready[2]), .Data_S_o(s2));
  seq_multiplier #(.W(32), .D(32)) u3 (.clk(clk), .rst_n(rst_n), .Start_i(start[3]), .Sgn_i(sgn),
    .Data_A_i(a),       .Data_B_i(b),       .Busy_o(busy[3]), .Ready_o(ready[3]), .Data_S_o(s3));
  seq_multiplier #(.W(16), .D(4))  u4 (.clk(clk), .rst_n(rst_n), .Start_i(start[4]), .Sgn_i(sgn),
    .Data_A_i(a[15:0]), .Data_B_i(b[15:0]), .Busy_o(busy[4]), .Ready_o(ready[4]), .Data_S_o(s4));

  function automatic int getW(input int idx);
    case (idx)
      0: return 8;
      4: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int getN(input int idx);
    case (idx)
      0: return 4;
      1: return 16;
      2: return 32;
      3: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [63:0] getS(input int idx);
    case (idx)
      0: return 64'(s0);
      1: return s1;
      2: return s2;
      3: return s3;
      default: return 64'(s4);
    endcase
  endfunction

  // Mathematical product of the w-bit operands (sign- or zero-extended), kept to 2w bits.
  function automatic logic [63:0] refProduct(input int w, input logic sg,
                                             input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] mask, ea, eb;
    mask = (64'd1 << w) - 64'd1;
    ea = {32'd0, av} & mask;
    eb = {32'd0, bv} & mask;
    if (sg && av[w-1]) ea = ea | ~mask;
    if (sg && bv[w-1]) eb = eb | ~mask;
    return (ea * eb) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic sg, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    sgn = sg;
    a = av;
    b = bv;
    start[idx] = 1'b1;
    @(posedge clk);
    #1 start[idx] = 1'b0;
  endtask

  task automatic runOp(input int idx, input logic sg, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] exp, input string tag);
    int lat;
    lat = 0;
    applyStimulus(idx, sg, av, bv);
    for (int k = 1; k <= getN(idx) + 4 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (ready[idx]) lat = k;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(getN(idx)));
    checkOutput({tag, " product"}, getS(idx), exp);
    @(posedge clk);
    #1;
    checkOutput({tag, " ready_fall"}, 64'(ready[idx]), 64'd0);
    checkOutput({tag, " busy_fall"}, 64'(busy[idx]), 64'd0);
    checkOutput({tag, " hold"}, getS(idx), exp);
  endtask

  initial begin
    logic [31:0] mask, minneg, maxpos, ra, rb;
    logic [31:0] pa[6];
    logic [31:0] pb[6];
    int w;
    logic seen;

    $display("[TB] reset check");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset ready", 64'(ready), 64'd0);
    checkOutput("reset data", 64'(s0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed W=8 D=2");
    runOp(0, 1'b0, 32'hFF, 32'hFF, 64'hFE01, "umax");
    runOp(0, 1'b1, 32'h80, 32'h80, 64'h4000, "s80x80");
    runOp(0, 1'b1, 32'hFF, 32'h7F, 64'hFF81, "sFFx7F");
    runOp(0, 1'b0, 32'hFF, 32'h7F, 64'h7E81, "uFFx7F");

    $display("[TB] start while busy");
    applyStimulus(0, 1'b0, 32'd3, 32'd5);
    @(posedge clk);
    applyStimulus(0, 1'b0, 32'd7, 32'd7);
    checkOutput("ign e2 busy", 64'(busy[0]), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("ign e3 ready", 64'(ready[0]), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("ign e4 ready", 64'(ready[0]), 64'd1);
    checkOutput("ign e4 data", 64'(s0), 64'h000F);
    applyStimulus(0, 1'b0, 32'd7, 32'd7);
    checkOutput("ign e5 ready", 64'(ready[0]), 64'd0);
    checkOutput("ign e5 busy", 64'(busy[0]), 64'd1);
    checkOutput("ign e5 hold", 64'(s0), 64'h000F);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ready[0]) seen = 1'b1;
    end
    checkOutput("ign e6-8 no ready", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("ign e9 ready", 64'(ready[0]), 64'd1);
    checkOutput("ign e9 data", 64'(s0), 64'h0031);
    @(posedge clk);
    #1;
    checkOutput("ign e10 busy", 64'(busy[0]), 64'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 1'b0, 32'd200, 32'd3);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst busy", 64'(busy[0]), 64'd0);
    checkOutput("midrst data", 64'(s0), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ready[0]) seen = 1'b1;
    end
    checkOutput("midrst no ready", 64'(seen), 64'd0);
    checkOutput("midrst data after", 64'(s0), 64'd0);
    runOp(0, 1'b0, 32'd200, 32'd3, 64'h0258, "after_rst");

    $display("[TB] parameter sweep");
    for (int idx = 1; idx <= 4; idx++) begin
      w = getW(idx);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      minneg = 32'd1 << (w - 1);
      maxpos = minneg - 32'd1;
      pa = '{32'd0, 32'd1, minneg, mask, maxpos, mask};
      pb = '{mask, minneg, minneg, mask, minneg, 32'd1};
      for (int p = 0; p < 6; p++) begin
        for (int s = 0; s < 2; s++) begin
          runOp(idx, s[0], pa[p], pb[p], refProduct(w, s[0], pa[p], pb[p]),
                $sformatf("cfg%0d dir%0d sg%0d", idx, p, s));
        end
      end
      for (int r = 0; r < 8; r++) begin
        ra = $urandom() & mask;
        rb = $urandom() & mask;
        runOp(idx, r[0], ra, rb, refProduct(w, r[0], ra, rb),
              $sformatf("cfg%0d rnd%0d", idx, r));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
